// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHSU = 3'd2;
    localparam logic [2:0] FN_MULHU  = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_DIVU   = 3'd5;
    localparam logic [2:0] FN_REM    = 3'd6;
    localparam logic [2:0] FN_REMU   = 3'd7;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Two's-complement negate when requested; used for magnitudes and sign fixup
    function automatic logic [31:0] negIf(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit and try a subtract.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};

    // A set top bit on the difference means the subtract borrowed, so restore
    always_comb begin
        o_quo = {i_quo[XLEN-2:0], ~w_diff[XLEN]};
        o_rem = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for EX: pipelined multiply, iterative divide,
// special-case shortcuts, repeat-request cache and flush handling.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_STEPS   = 32,
    parameter int XLEN        = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_m_cnt,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic [XLEN-1:0] o_out,
    output logic            o_ready,
    output logic            o_busy
);

    localparam int PIPE_N = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

    state_t          r_state;
    logic [5:0]      r_count;
    logic [2:0]      r_fn;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_out;
    logic            r_ready;
    logic [XLEN-1:0] r_mulPipe [PIPE_N];
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic            r_negQ;
    logic            r_negR;
    logic            r_isRem;
    logic            r_cValid;
    logic [2:0]      r_cFn;
    logic [XLEN-1:0] r_cRs1;
    logic [XLEN-1:0] r_cRs2;
    logic [XLEN-1:0] r_cRes;

    logic            w_rs1Signed;
    logic            w_rs2Signed;
    logic [2*XLEN-1:0] w_mulA;
    logic [2*XLEN-1:0] w_mulB;
    logic [2*XLEN-1:0] w_product;
    logic [XLEN-1:0] w_mulSel;
    logic [XLEN-1:0] w_mulTail;
    logic            w_divSigned;
    logic            w_isRem;
    logic            w_rs1Neg;
    logic            w_rs2Neg;
    logic            w_divZero;
    logic            w_overflow;
    logic [XLEN-1:0] w_special;
    logic            w_hit;
    logic [XLEN-1:0] w_remNext;
    logic [XLEN-1:0] w_quoNext;
    logic [XLEN-1:0] w_divResult;

    assign w_rs1Signed = (i_m_cnt == FN_MUL) || (i_m_cnt == FN_MULH) || (i_m_cnt == FN_MULHSU);
    assign w_rs2Signed = (i_m_cnt == FN_MUL) || (i_m_cnt == FN_MULH);
    assign w_mulA      = {{XLEN{w_rs1Signed & i_rs1[XLEN-1]}}, i_rs1};
    assign w_mulB      = {{XLEN{w_rs2Signed & i_rs2[XLEN-1]}}, i_rs2};
    assign w_product   = w_mulA * w_mulB;
    assign w_mulSel    = (i_m_cnt == FN_MUL) ? w_product[XLEN-1:0] : w_product[2*XLEN-1:XLEN];
    assign w_mulTail   = r_mulPipe[PIPE_N-1];

    assign w_divSigned = (i_m_cnt == FN_DIV) || (i_m_cnt == FN_REM);
    assign w_isRem     = (i_m_cnt == FN_REM) || (i_m_cnt == FN_REMU);
    assign w_rs1Neg    = w_divSigned & i_rs1[XLEN-1];
    assign w_rs2Neg    = w_divSigned & i_rs2[XLEN-1];
    assign w_divZero   = (i_rs2 == '0);
    assign w_overflow  = w_divSigned && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONES);
    assign w_special   = w_isRem ? (w_divZero ? i_rs1 : '0) : (w_divZero ? ALL_ONES : INT_MIN);

    assign w_hit = r_cValid && (r_cFn == i_m_cnt) && (r_cRs1 == i_rs1) && (r_cRs2 == i_rs2);

    div_step #(.XLEN(XLEN)) u_divStep (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_remNext),
        .o_quo (w_quoNext)
    );

    assign w_divResult = r_isRem ? negIf(w_remNext, r_negR) : negIf(w_quoNext, r_negQ);

    assign o_out   = r_out;
    assign o_ready = r_ready;
    assign o_busy  = (r_state != S_IDLE);

    // Sequencer: capture in IDLE, iterate in MUL/DIV, publish and cache in DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_fn     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_out    <= '0;
            r_ready  <= 1'b0;
            for (int k = 0; k < PIPE_N; k++) r_mulPipe[k] <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
            r_isRem  <= 1'b0;
            r_cValid <= 1'b0;
            r_cFn    <= '0;
            r_cRs1   <= '0;
            r_cRs2   <= '0;
            r_cRes   <= '0;
        end else begin
            r_ready <= 1'b0;
            if (i_kill) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_fn    <= i_m_cnt;
                            r_rs1   <= i_rs1;
                            r_rs2   <= i_rs2;
                            r_count <= '0;
                            if (w_hit) begin
                                r_out   <= r_cRes;
                                r_ready <= 1'b1;
                                r_state <= S_DONE;
                            end else if (!i_m_cnt[2]) begin
                                r_mulPipe[0] <= w_mulSel;
                                if (MUL_LATENCY == 1) begin
                                    r_out   <= w_mulSel;
                                    r_ready <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_state <= S_MUL;
                                end
                            end else if (w_divZero || w_overflow) begin
                                r_out   <= w_special;
                                r_ready <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_rem   <= '0;
                                r_quo   <= negIf(i_rs1, w_rs1Neg);
                                r_dvs   <= negIf(i_rs2, w_rs2Neg);
                                r_negQ  <= w_rs1Neg ^ w_rs2Neg;
                                r_negR  <= w_rs1Neg;
                                r_isRem <= w_isRem;
                                r_state <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        for (int k = 1; k < PIPE_N; k++) r_mulPipe[k] <= r_mulPipe[k-1];
                        if (r_count == 6'(MUL_LATENCY - 2)) begin
                            r_out   <= w_mulTail;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_count <= r_count + 6'd1;
                        end
                    end
                    S_DIV: begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        if (r_count == 6'(DIV_STEPS - 1)) begin
                            r_out   <= w_divResult;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_count <= r_count + 6'd1;
                        end
                    end
                    S_DONE: begin
                        r_cValid <= 1'b1;
                        r_cFn    <= r_fn;
                        r_cRs1   <= r_rs1;
                        r_cRs2   <= r_rs2;
                        r_cRes   <= r_out;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with hand-computed results and latencies.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [2:0]  i_m_cnt;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_kill;
    logic [31:0] o_out;
    logic        o_ready;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int lat;
    bit busyAll;
    bit sawReady;

    muldiv_ctrl #(.MUL_LATENCY(2), .DIV_STEPS(32), .XLEN(32)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_m_cnt (i_m_cnt),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_kill  (i_kill),
        .o_out   (o_out),
        .o_ready (o_ready),
        .o_busy  (o_busy)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Present a request on the falling edge; that cycle is t
    task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_m_cnt = fn;
        i_rs1   = a;
        i_rs2   = b;
        i_start = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Count cycles after t until READY, noting whether BUSY stayed high meanwhile
    task automatic waitReady(input int maxCyc, output int cyc, output bit busyHigh);
        cyc = -1;
        busyHigh = 1'b1;
        for (int i = 1; i <= maxCyc; i++) begin
            @(negedge i_clk);
            if (o_ready) begin
                cyc = i;
                return;
            end
            if (!o_busy) busyHigh = 1'b0;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expOut, input int expLat);
        applyStimulus(fn, a, b);
        waitReady(40, lat, busyAll);
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_out"}, o_out, expOut);
        i_start = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b1;
        i_start = 1'b0;
        i_kill  = 1'b0;
        i_m_cnt = '0;
        i_rs1   = '0;
        i_rs2   = '0;
        #1 i_rst_n = 1'b0;
        #2;
        checkOutput("rst_out", o_out, 32'h0);
        checkOutput("rst_ready", o_ready, 32'h0);
        checkOutput("rst_busy", o_busy, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        runOp("mul", FN_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        @(negedge i_clk);
        checkOutput("mul_ready_drop", o_ready, 32'h0);
        checkOutput("mul_busy_drop", o_busy, 32'h0);
        runOp("mulh", FN_MULH, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2);

        runOp("div", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        checkOutput("div_busy", busyAll, 32'h1);
        runOp("rem", FN_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

        runOp("divu_z", FN_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        runOp("remu_z", FN_REMU, 32'd100, 32'd0, 32'd100, 1);
        runOp("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        runOp("rem_ovf", FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Flush in the middle of a divide
        applyStimulus(FN_DIVU, 32'd50, 32'd3);
        sawReady = 1'b0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_ready) sawReady = 1'b1;
        end
        i_kill  = 1'b1;
        i_start = 1'b0;
        @(negedge i_clk);
        checkOutput("kill_busy", o_busy, 32'h0);
        i_kill = 1'b0;
        repeat (4) begin
            if (o_ready) sawReady = 1'b1;
            @(negedge i_clk);
        end
        checkOutput("kill_noready", sawReady, 32'h0);
        runOp("mulhu", FN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);

        // Repeat cache
        runOp("rep1", FN_DIVU, 32'd1000, 32'd7, 32'd142, 33);
        runOp("rep2", FN_DIVU, 32'd1000, 32'd7, 32'd142, 1);

        // Flush while the result is on the bus: cache keeps the older entry
        runOp("kdone", FN_DIVU, 32'd2000, 32'd7, 32'd285, 33);
        i_kill = 1'b1;
        @(negedge i_clk);
        checkOutput("kdone_busy", o_busy, 32'h0);
        i_kill = 1'b0;
        runOp("rep3", FN_DIVU, 32'd1000, 32'd7, 32'd142, 1);
        runOp("kdone2", FN_DIVU, 32'd2000, 32'd7, 32'd285, 33);

        // Asynchronous reset in the middle of a divide
        applyStimulus(FN_DIVU, 32'd300, 32'd5);
        repeat (5) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("arst_out", o_out, 32'h0);
        checkOutput("arst_ready", o_ready, 32'h0);
        checkOutput("arst_busy", o_busy, 32'h0);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        runOp("post_rst", FN_DIVU, 32'd2000, 32'd7, 32'd285, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer and arbiter for the RV32M multiply/divide resource used by the execute stage. It replaces the free-running multiply/divide unit with an explicit FSM.
- Accepts a level START from EX and runs a fixed-latency multiply or a 32-step iterative divide.
- Short-circuits RISC-V special cases and exact-repeat requests, and aborts cleanly on pipeline flush.
- READY has the same meaning as the existing stall handshake: EX stalls while START=1 and READY=0.

Parameters:
- MUL_LATENCY, 2, cycles from capture to result for funct3 0-3; legal range 1..8.
- DIV_STEPS, 32, restoring-divide iterations; fixed at 32 for RV32.
- XLEN, 32, operand and result width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request valid (level), held by EX until READY.
- M_CNT  in  3  funct3 opcode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- RS1  in  XLEN  rs1 operand (multiplicand / dividend).
- RS2  in  XLEN  rs2 operand (multiplier / divisor).
- KILL  in  1  flush from EX; aborts any operation.
- OUT  out  XLEN  result, valid when READY=1.
- READY  out  1  one-cycle result strobe.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; OUT=0, READY=0, BUSY=0.
  - Repeat cache invalid; step counter=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If START=1 and KILL=0, capture M_CNT, RS1 and RS2 (cycle t).
  - If the capture matches the repeat cache (valid, identical M_CNT/RS1/RS2), go to DONE with the cached result.
  - Otherwise, for M_CNT[2]=0, go to MUL.
  - Otherwise, if divisor=0 or the signed-overflow case applies, go to DONE.
  - Otherwise go to DIV.
- MUL:
  - Full 64-bit product, operand signedness per funct3 (MULHSU: rs1 signed, rs2 unsigned).
  - Counter runs MUL_LATENCY-1 cycles, then goes to DONE.
  - READY is high in cycle t+MUL_LATENCY.
  - Result is product[31:0] for MUL, product[63:32] otherwise.
- DIV:
  - Operands converted to magnitudes at capture (signed ops only).
  - One restoring step per cycle for DIV_STEPS cycles (t+1..t+32).
  - Sign fixup on entry to DONE: quotient negated if signs differ; remainder takes the dividend's sign.
  - READY is high in cycle t+33.
- Special cases, both reaching DONE at t+1:
  - Divisor=0: DIV/DIVU returns 0xFFFFFFFF; REM/REMU returns RS1.
  - Overflow (DIV/REM, RS1=0x80000000, RS2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE:
  - READY=1 and OUT holds the result for exactly one cycle, then back to IDLE.
  - Repeat cache is loaded with {M_CNT, RS1, RS2, OUT}.
  - In the following IDLE cycle, START=1 is treated as a new request; EX deasserts START or presents the next instruction.
- READY is 0 in every state except DONE. OUT holds its last value outside DONE; only READY qualifies it.
- KILL:
  - In any state, the next state is IDLE with READY=0.
  - The in-flight result is discarded and the repeat cache is not updated.
  - KILL and START together in IDLE: KILL wins, no capture.
  - KILL in DONE: READY still asserted that cycle; EX is already masking it.
- Operand changes while BUSY are ignored; captured copies are used.
- Reset mid-operation: immediate return to the reset state; the cache is invalidated.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - FSM state encodings (IDLE, MUL, DIV, DONE).
  - Constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and quotient.
  - Instantiated once and iterated by the FSM.
- The multiplier is inferred inline, with a pipeline depth of MUL_LATENCY registers.

Test Plan:
- MUL, RS1=7, RS2=-3 (0xFFFFFFFD), START at t -> READY=1 at t+2, OUT=0xFFFFFFEB; MULH of the same operands -> OUT=0xFFFFFFFF.
- DIV, RS1=-7, RS2=2 -> READY at t+33, OUT=0xFFFFFFFD; REM of the same operands -> OUT=0xFFFFFFFF; BUSY high t+1..t+32.
- DIVU, RS1=100, RS2=0 -> READY at t+1, OUT=0xFFFFFFFF; REMU -> OUT=100; DIV with 0x80000000 / 0xFFFFFFFF -> OUT=0x80000000 at t+1.
- KILL asserted at t+10 of a DIV -> IDLE at t+11, READY never asserted; new MULHU 0xFFFFFFFF*0xFFFFFFFF -> OUT=0xFFFFFFFE after MUL_LATENCY.
- Repeat DIVU 1000/7 twice -> first READY at t+33 with OUT=142; second READY one cycle after capture with OUT=142; the repeat cache is unchanged by a killed request.
- RST_N pulsed low mid-DIV (asynchronous, off-edge) -> OUT=0, READY=0, BUSY=0 immediately; the next identical request takes the full 33 cycles.
